// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - req/ready data bus between load_store_unit and memory/peripherals
interface load_store_unit_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        ready;

   modport master (output req, we, be, addr, wd, input rd, ready);
   modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - core data-side bridge to a req/ready bus with byte enables and load extension
// Optional feature macro: LSU_MISALIGN_EXC_EN rejects misaligned H/W accesses instead of force-aligning them.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [2:0]        core_size_i,
   input  logic [31:0]       core_addr_i,
   input  logic [31:0]       core_wd_i,
   output logic [31:0]       core_rd_o,
   output logic              core_stall_o,
   output logic              core_misalign_o,
   output logic              core_bus_err_o,
   load_store_unit_if.master mem
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] rd_q, rd_d;
   logic [31:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        mis_q, mis_d;

   logic [1:0]  off;
   logic        is_b, is_h, sgn;
   logic        misalign, active, req, timeout;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_ext;

   assign off  = core_addr_i[1:0];
   assign is_b = (core_size_i[1:0] == 2'd0);
   assign is_h = (core_size_i[1:0] == 2'd1);
   assign sgn  = ~core_size_i[2];

`ifdef LSU_MISALIGN_EXC_EN
   assign misalign = (is_h & off[0]) | (~is_b & ~is_h & (off != 2'd0));
`else
   assign misalign = 1'b0;
`endif

   // rst_ni gates the request path so the bus sees no request the instant reset asserts
   assign active  = rst_ni & core_req_i & (state_q != DONE);
   assign req     = active & ~misalign;
   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      lane_b = mem.rd[{off, 3'b000} +: 8];
      lane_h = off[1] ? mem.rd[31:16] : mem.rd[15:0];
      if (is_b)
         load_ext = {{24{sgn & lane_b[7]}}, lane_b};
      else if (is_h)
         load_ext = {{16{sgn & lane_h[15]}}, lane_h};
      else
         load_ext = mem.rd;
   end

   always_comb begin
      mem.req  = req;
      mem.we   = 1'b0;
      mem.be   = 4'b0000;
      mem.addr = 32'd0;
      mem.wd   = 32'd0;
      if (req) begin
         mem.we   = core_we_i;
         mem.addr = {core_addr_i[31:2], 2'b00};
         if (is_b) begin
            mem.be = 4'b0001 << off;
            mem.wd = {4{core_wd_i[7:0]}};
         end else if (is_h) begin
            mem.be = 4'b0011 << {off[1], 1'b0};
            mem.wd = {2{core_wd_i[15:0]}};
         end else begin
            mem.be = 4'b1111;
            mem.wd = core_wd_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      cnt_d   = 32'd0;
      err_d   = 1'b0;
      mis_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (core_req_i) begin
               if (misalign) begin
                  rd_d    = 32'd0;
                  mis_d   = 1'b1;
                  state_d = DONE;
               end else if (req && mem.ready) begin
                  if (!core_we_i) rd_d = load_ext;
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            // a dropped request means the core trapped; the bus is simply abandoned
            if (!core_req_i) begin
               state_d = IDLE;
            end else if (req && mem.ready) begin
               if (!core_we_i) rd_d = load_ext;
               state_d = DONE;
            end else if (timeout) begin
               rd_d    = 32'd0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rd_q    <= 32'd0;
         cnt_q   <= 32'd0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   assign core_rd_o       = rd_q;
   assign core_stall_o    = active;
   assign core_bus_err_o  = err_q;
   assign core_misalign_o = mis_q;
endmodule
